// File: rtl/mmio_io_responder_pkg.sv
// mmio_io_responder_pkg
// Shared constants for the memory-mapped I/O responder: the peripheral
// address map, the button index order inside btn_raw, the status-word bit
// layout, the mailbox state type and a helper that maps a button index to
// its read address.
package mmio_io_responder_pkg;

    // Peripheral address map (processor byte addresses, full 32-bit compare)
    localparam logic [31:0] ADDR_BTNC = 32'd1000;
    localparam logic [31:0] ADDR_BTNL = 32'd3000;
    localparam logic [31:0] ADDR_BTNR = 32'd4000;
    localparam logic [31:0] ADDR_BTNU = 32'd5000;
    localparam logic [31:0] ADDR_BTND = 32'd6000;
    localparam logic [31:0] ADDR_OUT  = 32'd2000;
    localparam logic [31:0] ADDR_STAT = 32'd2004;
    localparam logic [31:0] ADDR_OVR  = 32'd2008;

    // Button positions inside btn_raw = {D,U,R,L,C}
    localparam int NUM_BTN = 5;
    localparam int BTN_C   = 0;
    localparam int BTN_L   = 1;
    localparam int BTN_R   = 2;
    localparam int BTN_U   = 3;
    localparam int BTN_D   = 4;

    // Status word: bit that reports "mailbox holds unconsumed data"
    localparam int STAT_VALID_BIT = 0;

    // Overrun counter width and its saturation value
    localparam int                OVR_W   = 16;
    localparam logic [OVR_W-1:0] OVR_MAX = '1;

    // Mailbox occupancy
    typedef enum logic {
        MB_EMPTY = 1'b0,
        MB_FULL  = 1'b1
    } mb_state_e;

    // Read address of the sticky flag for button index idx
    function automatic logic [31:0] btn_addr(input int idx);
        case (idx)
            BTN_C:   return ADDR_BTNC;
            BTN_L:   return ADDR_BTNL;
            BTN_R:   return ADDR_BTNR;
            BTN_U:   return ADDR_BTNU;
            default: return ADDR_BTND;
        endcase
    endfunction

endpackage

// File: rtl/mmio_io_responder_if.sv
// mmio_io_responder_if
// Processor data-memory port plus the VGA mailbox handshake.
//   address_dmem / data / wren : processor access (write when wren=1)
//   q_ram                      : RAM read data, one-cycle registered read
//   q_dmem                     : read data returned to the processor
//   to_vga / to_vga_valid      : mailbox contents and occupancy
//   vga_ack                    : VGA consumed the mailbox this cycle
// slave  = responder side, master = processor/RAM/VGA environment side.
interface mmio_io_responder_if;
    logic [31:0] address_dmem;
    logic [31:0] data;
    logic        wren;
    logic [31:0] q_ram;
    logic [31:0] q_dmem;
    logic [31:0] to_vga;
    logic        to_vga_valid;
    logic        vga_ack;

    modport slave (
        input  address_dmem, data, wren, q_ram, vga_ack,
        output q_dmem, to_vga, to_vga_valid
    );

    modport master (
        output address_dmem, data, wren, q_ram, vga_ack,
        input  q_dmem, to_vga, to_vga_valid
    );
endinterface

// File: rtl/mmio_io_responder_io_debounce.sv
// mmio_io_responder_io_debounce
// One button path: 2-flop synchronizer, stability counter and press pulse.
//   clock, reset : system clock, synchronous active-high reset
//   btn_raw_i    : asynchronous raw button level
//   press_o      : high for one cycle when the debounced level is about to
//                  go 0->1 (the level register takes the new value on the
//                  same edge that ends the pulse)
module mmio_io_responder_io_debounce #(
    parameter int DB_CYCLES = 100000,
    parameter int CNT_W     = 17
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_raw_i,
    output logic press_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // The counter only runs while the synchronized input disagrees with the
    // debounced level; any agreeing sample restarts the stability window.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign press_o = level_d & ~level_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_raw_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/mmio_io_responder.sv
// mmio_io_responder
// Memory-mapped I/O responder on the processor data-memory port.
//   clock, reset : system clock, synchronous active-high reset
//   btn_raw      : raw buttons {D,U,R,L,C}, asynchronous
//   bus          : processor port + VGA mailbox (see mmio_io_responder_if)
// Button addresses read debounced, sticky press flags (cleared by the read).
// ADDR_OUT writes fill a one-entry mailbox toward the VGA controller;
// ADDR_STAT/ADDR_OVR report its occupancy and overrun count. Reads of
// mapped addresses return one cycle later, aligned with the RAM latency;
// all other addresses pass q_ram through.
module mmio_io_responder
    import mmio_io_responder_pkg::*;
#(
    parameter int DB_CYCLES = 100000,
    parameter int CNT_W     = 17
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_raw,
    mmio_io_responder_if.slave bus
);

    logic               is_read;
    logic               wr_out;
    logic [NUM_BTN-1:0] press;
    logic [NUM_BTN-1:0] rd_hit;
    logic [NUM_BTN-1:0] flag_q;
    logic [NUM_BTN-1:0] flag_d;

    logic               sel_q;
    logic               sel_d;
    logic [31:0]        periph_q;
    logic [31:0]        periph_d;

    mb_state_e          mb_q;
    mb_state_e          mb_d;
    logic [31:0]        to_vga_q;
    logic [31:0]        to_vga_d;
    logic [OVR_W-1:0]   ovr_q;
    logic [OVR_W-1:0]   ovr_d;

    assign is_read = ~bus.wren;
    assign wr_out  = bus.wren && (bus.address_dmem == ADDR_OUT);

    // Per-button debounce and sticky flag. A press in the same cycle as a
    // clearing read leaves the flag set; the read itself sees the old value
    // because periph_q samples flag_q, not flag_d.
    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
        mmio_io_responder_io_debounce #(
            .DB_CYCLES (DB_CYCLES),
            .CNT_W     (CNT_W)
        ) u_io_debounce (
            .clock     (clock),
            .reset     (reset),
            .btn_raw_i (btn_raw[gi]),
            .press_o   (press[gi])
        );

        assign rd_hit[gi] = is_read && (bus.address_dmem == btn_addr(gi));
        assign flag_d[gi] = press[gi] | (flag_q[gi] & ~rd_hit[gi]);
    end

    // Read decode: what the processor sees one cycle after the address.
    always_comb begin
        sel_d    = 1'b0;
        periph_d = '0;
        if (is_read) begin
            for (int i = 0; i < NUM_BTN; i++) begin
                if (bus.address_dmem == btn_addr(i)) begin
                    sel_d       = 1'b1;
                    periph_d[0] = flag_q[i];
                end
            end
            if (bus.address_dmem == ADDR_STAT) begin
                sel_d                    = 1'b1;
                periph_d[STAT_VALID_BIT] = (mb_q == MB_FULL);
            end
            if (bus.address_dmem == ADDR_OVR) begin
                sel_d    = 1'b1;
                periph_d = {{(32-OVR_W){1'b0}}, ovr_q};
            end
            if (bus.address_dmem == ADDR_OUT) begin
                sel_d = 1'b1;
            end
        end
    end

    // Mailbox: a write into a full, unacknowledged mailbox overwrites the
    // data and counts an overrun; an ack in the same cycle as a write means
    // the old entry was consumed, so the new one is not an overrun.
    always_comb begin
        mb_d     = mb_q;
        to_vga_d = to_vga_q;
        ovr_d    = ovr_q;
        case (mb_q)
            MB_EMPTY: begin
                if (wr_out) begin
                    to_vga_d = bus.data;
                    mb_d     = MB_FULL;
                end
            end
            MB_FULL: begin
                if (wr_out) begin
                    to_vga_d = bus.data;
                    if (!bus.vga_ack && (ovr_q != OVR_MAX)) begin
                        ovr_d = ovr_q + 16'd1;
                    end
                end else if (bus.vga_ack) begin
                    mb_d = MB_EMPTY;
                end
            end
            default: mb_d = MB_EMPTY;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            flag_q   <= '0;
            sel_q    <= 1'b0;
            periph_q <= '0;
            mb_q     <= MB_EMPTY;
            to_vga_q <= '0;
            ovr_q    <= '0;
        end else begin
            flag_q   <= flag_d;
            sel_q    <= sel_d;
            periph_q <= periph_d;
            mb_q     <= mb_d;
            to_vga_q <= to_vga_d;
            ovr_q    <= ovr_d;
        end
    end

    assign bus.q_dmem       = sel_q ? periph_q : bus.q_ram;
    assign bus.to_vga       = to_vga_q;
    assign bus.to_vga_valid = (mb_q == MB_FULL);

endmodule
